// File: rtl/sha256_preproc_wide.sv
// sha256_preproc_wide: packs a byte stream into SHA-256 message blocks.
// The stream arrives in IN_BYTES-wide beats, MSB byte first. The module appends
// the 0x80 marker, the zero fill and the 64-bit big-endian bit length.
// A trailing beat that leaves no room for the length spills into one extra block.
// Optional macro SHA256_PREPROC_PROTO_CHK_EN enables the sticky dkeep protocol
// check on err. Without it, err is tied to 0.
module sha256_preproc_wide #(
   parameter int IN_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [8*IN_BYTES-1:0]   din,
   input  logic [IN_BYTES-1:0]     dkeep,
   input  logic                    dvalid,
   input  logic                    dlast,
   output logic                    ready,
   output logic                    block_valid,
   input  logic                    block_ready,
   output logic                    final_block,
   output logic [511:0]            msg_padded,
   output logic                    err
);

   typedef enum logic [1:0] {ACCUM, EMIT, EMIT_PAD, EMIT_LEN} state_t;

   state_t        r_state;
   logic [6:0]    r_ptr;
   logic [63:0]   r_len;
   logic [511:0]  r_buf;
   logic          r_ready;
   logic          r_bv;
   logic          r_final;
   logic          r_pad80;

   logic          w_accept;
   logic [6:0]    w_lead;
   logic [6:0]    w_cnt;
   logic [6:0]    w_end;
   logic [63:0]   w_len_next;
   logic [511:0]  w_fill_buf;

   assign w_accept   = dvalid & r_ready;
   assign w_cnt      = dlast ? w_lead : 7'(IN_BYTES);
   assign w_end      = r_ptr + w_cnt;
   assign w_len_next = r_len + {54'd0, w_cnt, 3'b000};

   // Count the contiguous run of ones in dkeep starting at the MSB.
   always_comb begin : p_lead
      logic v_run;
      v_run  = 1'b1;
      w_lead = 7'd0;
      for (int k = IN_BYTES - 1; k >= 0; k--) begin
         if (v_run && dkeep[k]) begin
            w_lead = w_lead + 7'd1;
         end else begin
            v_run = 1'b0;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 64; gi++) begin : g_byte
         // Length bytes 56..63 carry len MSB first; other bytes never use it.
         localparam int LEN_LSB = (gi >= 56) ? 8 * (63 - gi) : 0;
         logic [7:0] w_byte;

         // Next value of this buffer byte: beat data, marker, zero fill or length.
         always_comb begin
            w_byte = r_buf[511-8*gi -: 8];
            for (int k = 0; k < IN_BYTES; k++) begin
               if ((7'(gi) == r_ptr + 7'(k)) && (7'(k) < w_cnt)) begin
                  w_byte = din[8*(IN_BYTES-1-k) +: 8];
               end
            end
            if (dlast) begin
               if (7'(gi) == w_end) begin
                  w_byte = 8'h80;
               end else if (7'(gi) > w_end) begin
                  w_byte = 8'h00;
               end
               if ((gi >= 56) && (w_end <= 7'd55)) begin
                  w_byte = w_len_next[LEN_LSB +: 8];
               end
            end
         end

         assign w_fill_buf[511-8*gi -: 8] = w_byte;
      end
   endgenerate

   // Block assembly and emit state machine with registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ACCUM;
         r_ptr   <= 7'd0;
         r_len   <= 64'd0;
         r_buf   <= 512'd0;
         r_ready <= 1'b0;
         r_bv    <= 1'b0;
         r_final <= 1'b0;
         r_pad80 <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               r_ready <= 1'b1;
               if (w_accept) begin
                  r_len <= w_len_next;
                  r_buf <= w_fill_buf;
                  if (!dlast) begin
                     if (w_end == 7'd64) begin
                        r_state <= EMIT;
                        r_bv    <= 1'b1;
                        r_final <= 1'b0;
                        r_ready <= 1'b0;
                        r_ptr   <= 7'd0;
                     end else begin
                        r_ptr <= w_end;
                     end
                  end else begin
                     r_ready <= 1'b0;
                     r_bv    <= 1'b1;
                     r_ptr   <= w_end;
                     if (w_end <= 7'd55) begin
                        r_state <= EMIT_LEN;
                        r_final <= 1'b1;
                     end else begin
                        r_state <= EMIT_PAD;
                        r_final <= 1'b0;
                        r_pad80 <= (w_end == 7'd64);
                     end
                  end
               end
            end
            EMIT: begin
               if (block_ready) begin
                  r_bv    <= 1'b0;
                  r_buf   <= 512'd0;
                  r_state <= ACCUM;
                  r_ready <= 1'b1;
               end
            end
            EMIT_PAD: begin
               if (block_ready) begin
                  r_buf   <= {(r_pad80 ? 8'h80 : 8'h00), 440'd0, r_len};
                  r_final <= 1'b1;
                  r_state <= EMIT_LEN;
               end
            end
            EMIT_LEN: begin
               if (block_ready) begin
                  r_bv    <= 1'b0;
                  r_final <= 1'b0;
                  r_buf   <= 512'd0;
                  r_ptr   <= 7'd0;
                  r_len   <= 64'd0;
                  r_pad80 <= 1'b0;
                  r_state <= ACCUM;
                  r_ready <= 1'b1;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign ready       = r_ready;
   assign block_valid = r_bv;
   assign final_block = r_final;
   assign msg_padded  = r_buf;

`ifdef SHA256_PREPROC_PROTO_CHK_EN
   logic                r_err;
   logic [IN_BYTES-1:0] w_keep_mask;

   // Mask of the leading-ones run; any dlast dkeep differing from it has holes.
   always_comb begin
      w_keep_mask = '0;
      for (int k = 0; k < IN_BYTES; k++) begin
         w_keep_mask[k] = (7'(IN_BYTES - 1 - k) < w_lead);
      end
   end

   // Sticky flag for malformed dkeep on any accepted beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_accept && (dlast ? (dkeep != w_keep_mask) : (dkeep != '1))) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_preproc_wide.sv
// Scoreboard bench for sha256_preproc_wide. It uses one 4-byte instance and one
// 1-byte instance that share clk and rst. Stimulus pushes expected blocks and
// the monitors pop them on each block handshake.
module tb_sha256_preproc_wide;

   logic          clk = 1'b0;
   logic          rst = 1'b0;

   logic [31:0]   din4 = '0;
   logic [3:0]    dkeep4 = '0;
   logic          dvalid4 = 1'b0;
   logic          dlast4 = 1'b0;
   logic          ready4;
   logic          bv4;
   logic          brdy4 = 1'b1;
   logic          fin4;
   logic [511:0]  msg4;
   logic          err4;

   logic [7:0]    din1 = '0;
   logic [0:0]    dkeep1 = '0;
   logic          dvalid1 = 1'b0;
   logic          dlast1 = 1'b0;
   logic          ready1;
   logic          bv1;
   logic          brdy1 = 1'b1;
   logic          fin1;
   logic [511:0]  msg1;
   logic          err1;

   typedef struct {
      logic [511:0] blk;
      logic         fin;
   } exp_t;

   exp_t exp4[$];
   exp_t exp1[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sha256_preproc_wide #(.IN_BYTES(4)) u_dut4 (
      .clk(clk), .rst(rst), .din(din4), .dkeep(dkeep4), .dvalid(dvalid4),
      .dlast(dlast4), .ready(ready4), .block_valid(bv4), .block_ready(brdy4),
      .final_block(fin4), .msg_padded(msg4), .err(err4)
   );

   sha256_preproc_wide #(.IN_BYTES(1)) u_dut1 (
      .clk(clk), .rst(rst), .din(din1), .dkeep(dkeep1), .dvalid(dvalid1),
      .dlast(dlast1), .ready(ready1), .block_valid(bv1), .block_ready(brdy1),
      .final_block(fin1), .msg_padded(msg1), .err(err1)
   );

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic push4(input logic [511:0] b, input logic f);
      exp_t e;
      e.blk = b;
      e.fin = f;
      exp4.push_back(e);
   endtask

   // Present one beat on the 4-byte instance and hold it until it is accepted.
   task automatic send4(input logic [31:0] d, input logic [3:0] k, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      din4 = d; dkeep4 = k; dlast4 = l; dvalid4 = 1'b1;
      while (!ready4 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send4_timeout got=ready0 want=ready1");
      end
      @(posedge clk);
      #1 dvalid4 = 1'b0;
   endtask

   // Present one beat on the 1-byte instance and hold it until it is accepted.
   task automatic send1(input logic [7:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      din1 = d; dkeep1 = 1'b1; dlast1 = l; dvalid1 = 1'b1;
      while (!ready1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL send1_timeout got=ready0 want=ready1");
      end
      @(posedge clk);
      #1 dvalid1 = 1'b0;
   endtask

   // Monitor for the 4-byte instance: a handshake takes place on the next rising edge.
   always @(negedge clk) begin
      if (rst && bv4 && brdy4) begin
         if (exp4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL blk4_unexpected got=%0h want=none", msg4);
         end else begin
            exp_t e;
            e = exp4.pop_front();
            chk("blk4_data", msg4, e.blk);
            chk("blk4_final", {511'd0, fin4}, {511'd0, e.fin});
            $display("blk4 final=%0b data=%0h", fin4, msg4);
         end
      end
   end

   // Monitor for the 1-byte instance.
   always @(negedge clk) begin
      if (rst && bv1 && brdy1) begin
         if (exp1.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL blk1_unexpected got=%0h want=none", msg1);
         end else begin
            exp_t e;
            e = exp1.pop_front();
            chk("blk1_data", msg1, e.blk);
            chk("blk1_final", {511'd0, fin1}, {511'd0, e.fin});
            $display("blk1 final=%0b data=%0h", fin1, msg1);
         end
      end
   end

   initial begin
      logic exp_err;
      exp_t e1;
      int   n;
`ifdef SHA256_PREPROC_PROTO_CHK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_ready4", {511'd0, ready4}, 512'd0);
      chk("rst_bv4", {511'd0, bv4}, 512'd0);
      chk("rst_fin4", {511'd0, fin4}, 512'd0);
      chk("rst_msg4", msg4, 512'd0);
      chk("rst_err4", {511'd0, err4}, 512'd0);
      chk("rst_ready1", {511'd0, ready1}, 512'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", {511'd0, ready4}, {511'd0, 1'b1});

      // 56 bytes of 0x61: the marker fits, but the length spills into a second block.
      push4({{56{8'h61}}, 8'h80, 56'd0}, 1'b0);
      push4({448'd0, 64'h1C0}, 1'b1);
      for (int i = 0; i < 14; i++) send4(32'h61616161, 4'hF, (i == 13));

      // 65 bytes of 0x61: a full block, then one byte with padding and length.
      push4({64{8'h61}}, 1'b0);
      push4({8'h61, 8'h80, 432'd0, 64'h208}, 1'b1);
      for (int i = 0; i < 16; i++) send4(32'h61616161, 4'hF, 1'b0);
      send4(32'h61AABBCC, 4'b1000, 1'b1);

      // Reset mid-message drops the partial data.
      for (int i = 0; i < 3; i++) send4(32'h63636363, 4'hF, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_msg4", msg4, 512'd0);
      chk("midrst_ready4", {511'd0, ready4}, 512'd0);
      rst = 1'b1;

      // Empty message: the first beat is dlast with dkeep=0000.
      push4({8'h80, 440'd0, 64'd0}, 1'b1);
      send4(32'hDEADBEEF, 4'b0000, 1'b1);

      // Back-pressure: hold the block for 10 cycles while a beat waits.
      @(posedge clk);
      #1 brdy4 = 1'b0;
      push4({64{8'h62}}, 1'b0);
      push4({8'h80, 440'd0, 64'h200}, 1'b1);
      for (int i = 0; i < 16; i++) send4(32'h62626262, 4'hF, 1'b0);
      fork
         send4(32'h11223344, 4'b0000, 1'b1);
         begin
            for (int c = 0; c < 10; c++) begin
               @(negedge clk);
               chk("stall_ready", {511'd0, ready4}, 512'd0);
               chk("stall_bv", {511'd0, bv4}, {511'd0, 1'b1});
               chk("stall_msg", msg4, {64{8'h62}});
            end
            @(posedge clk);
            #1 brdy4 = 1'b1;
         end
      join
      @(negedge clk);
      chk("err_clean", {511'd0, err4}, 512'd0);

      // dkeep=1010 on dlast counts as one byte and trips the optional protocol check.
      push4({8'h41, 8'h80, 432'd0, 64'h8}, 1'b1);
      send4(32'h41425152, 4'b1010, 1'b1);
      @(negedge clk);
      chk("err_set", {511'd0, err4}, {511'd0, exp_err});
      repeat (4) @(negedge clk);
      chk("err_sticky", {511'd0, err4}, {511'd0, exp_err});

      // IN_BYTES=1: "abc" with idle gaps between beats.
      e1.blk = {8'h61, 8'h62, 8'h63, 8'h80, 416'd0, 64'h18};
      e1.fin = 1'b1;
      exp1.push_back(e1);
      send1(8'h61, 1'b0);
      repeat (3) @(posedge clk);
      send1(8'h62, 1'b0);
      repeat (3) @(posedge clk);
      send1(8'h63, 1'b1);

      // Drain the scoreboards.
      n = 0;
      while ((exp4.size() != 0 || exp1.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      chk("drain4", 512'(exp4.size()), 512'd0);
      chk("drain1", 512'(exp1.size()), 512'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
